// File: rtl/conv1d_pe_row_if.sv
// Stream bundle for conv1d_pe_row: weight stream, activation stream and
// result stream, each with a valid/ready handshake.
interface conv1d_pe_row_if #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 32
);
   logic              w_valid;
   logic              w_ready;
   logic [DATA_W-1:0] w_data;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_data;
   logic              out_last;

   // Producer of weights/activations and consumer of results
   modport master (
      output w_valid, w_data, in_valid, in_data, out_ready,
      input  w_ready, in_ready, out_valid, out_data, out_last
   );

   // The processing row itself
   modport slave (
      input  w_valid, w_data, in_valid, in_data, out_ready,
      output w_ready, in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/conv1d_pe_row.sv
// One row of NUM_PE multiply-accumulate taps computing a 1-D convolution.
// A job loads NUM_PE weights, then streams K activations; every activation
// from the (NUM_PE-1)th onward yields one result one cycle later through a
// single output register that can be refilled in the same cycle it drains.
module conv1d_pe_row #(
   parameter int DATA_W = 8,
   parameter int NUM_PE = 4,
   parameter int ACC_W  = 32,
   parameter int SAT    = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           cfg_start,
   input  logic [15:0]    cfg_len,
   conv1d_pe_row_if.slave strm,
   output logic           busy,
   output logic           err,
   output logic           done
);
   localparam int PROD_W = 2 * DATA_W;
   localparam int SUM_W  = PROD_W + $clog2(NUM_PE);
   // one guard bit above the wider of sum/result so clamping compares are exact
   localparam int EXT_W  = ((SUM_W > ACC_W) ? SUM_W : ACC_W) + 1;
   localparam int WC_W   = $clog2(NUM_PE);
   localparam logic [WC_W-1:0] W_LAST = WC_W'(NUM_PE - 1);
   localparam logic [15:0]     WARM_N = 16'(NUM_PE - 1);
   localparam logic [15:0]     MIN_LEN = 16'(NUM_PE);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD_W  = 2'd1,
      COMPUTE = 2'd2,
      DRAIN   = 2'd3
   } state_t;

   state_t                   state_r;
   state_t                   state_s;
   logic [15:0]              len_r;
   logic [15:0]              in_cnt_r;
   logic [WC_W-1:0]          wcnt_r;
   logic signed [DATA_W-1:0] w_r    [NUM_PE];
   logic signed [DATA_W-1:0] win_r  [NUM_PE-1];
   logic signed [DATA_W-1:0] taps_s [NUM_PE];
   logic signed [PROD_W-1:0] prod_s;
   logic signed [SUM_W-1:0]  sum_s;
   logic                     out_valid_r;
   logic                     out_last_r;
   logic [ACC_W-1:0]         out_data_r;
   logic                     err_r;
   logic                     done_r;
   logic                     w_ready_s;
   logic                     in_ready_s;
   logic                     w_hs_s;
   logic                     in_hs_s;
   logic                     out_hs_s;
   logic                     emit_s;
   logic                     last_act_s;
   logic                     start_ok_s;
   logic                     start_bad_s;

   // Narrow the full-precision sum to ACC_W: clamp when SAT is set, else wrap.
   function automatic logic [ACC_W-1:0] reduce_sum(input logic signed [SUM_W-1:0] s);
      logic signed [EXT_W-1:0] ext;
      logic signed [EXT_W-1:0] hi;
      logic signed [EXT_W-1:0] lo;
      ext = {{(EXT_W-SUM_W){s[SUM_W-1]}}, s};
      hi  = '0;
      hi[ACC_W-2:0] = '1;
      lo  = '1;
      lo[ACC_W-2:0] = '0;
      if ((SAT != 32'sd0) && (ext > hi)) begin
         reduce_sum = hi[ACC_W-1:0];
      end else if ((SAT != 32'sd0) && (ext < lo)) begin
         reduce_sum = lo[ACC_W-1:0];
      end else begin
         reduce_sum = ext[ACC_W-1:0];
      end
   endfunction

   // Ready decode and handshake qualification for all three streams
   always_comb begin
      w_ready_s  = (state_r == LOAD_W);
      in_ready_s = (state_r == COMPUTE) && (!out_valid_r || strm.out_ready);
      w_hs_s     = strm.w_valid && w_ready_s;
      in_hs_s    = strm.in_valid && in_ready_s;
      out_hs_s   = out_valid_r && strm.out_ready;
      emit_s     = in_hs_s && (in_cnt_r >= WARM_N);
      last_act_s = in_hs_s && (in_cnt_r == (len_r - 16'd1));
   end

   // Next-state logic and job start qualification
   always_comb begin
      state_s     = state_r;
      start_ok_s  = 1'b0;
      start_bad_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (cfg_start) begin
               if (cfg_len >= MIN_LEN) begin
                  start_ok_s = 1'b1;
                  state_s    = LOAD_W;
               end else begin
                  start_bad_s = 1'b1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         LOAD_W: begin
            if (w_hs_s && (wcnt_r == W_LAST)) begin
               state_s = COMPUTE;
            end else begin
               state_s = LOAD_W;
            end
         end
         COMPUTE: begin
            if (last_act_s) begin
               state_s = DRAIN;
            end else begin
               state_s = COMPUTE;
            end
         end
         DRAIN: begin
            if (out_hs_s && out_last_r) begin
               state_s = IDLE;
            end else begin
               state_s = DRAIN;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // Dot product of the weights with the current activation plus the window
   always_comb begin
      taps_s[0] = $signed(strm.in_data);
      for (int i = 1; i < NUM_PE; i++) begin
         taps_s[i] = win_r[i-1];
      end
      prod_s = '0;
      sum_s  = '0;
      for (int i = 0; i < NUM_PE; i++) begin
         prod_s = w_r[i] * taps_s[i];
         sum_s  = sum_s + {{(SUM_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Job length and the weight / activation counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         len_r    <= 16'd0;
         in_cnt_r <= 16'd0;
         wcnt_r   <= '0;
      end else if (start_ok_s) begin
         len_r    <= cfg_len;
         in_cnt_r <= 16'd0;
         wcnt_r   <= '0;
      end else begin
         if (w_hs_s) begin
            wcnt_r <= wcnt_r + WC_W'(1);
         end
         if (in_hs_s) begin
            in_cnt_r <= in_cnt_r + 16'd1;
         end
      end
   end

   // Weight registers, filled tap 0 first
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_PE; i++) begin
            w_r[i] <= '0;
         end
      end else if (w_hs_s) begin
         w_r[wcnt_r] <= $signed(strm.w_data);
      end
   end

   // Activation window: newest sample enters at slot 0
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_PE - 1; i++) begin
            win_r[i] <= '0;
         end
      end else if (start_ok_s) begin
         for (int i = 0; i < NUM_PE - 1; i++) begin
            win_r[i] <= '0;
         end
      end else if (in_hs_s) begin
         win_r[0] <= $signed(strm.in_data);
         for (int i = 1; i < NUM_PE - 1; i++) begin
            win_r[i] <= win_r[i-1];
         end
      end
   end

   // Result register: a new result wins over a simultaneous drain
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
         out_data_r  <= '0;
      end else if (emit_s) begin
         out_valid_r <= 1'b1;
         out_last_r  <= last_act_s;
         out_data_r  <= reduce_sum(sum_s);
      end else if (out_hs_s) begin
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
      end
   end

   // Single-cycle status pulses for rejected start and job completion
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_r  <= 1'b0;
         done_r <= 1'b0;
      end else begin
         err_r  <= start_bad_s;
         done_r <= (state_r == DRAIN) && out_hs_s && out_last_r;
      end
   end

   assign strm.w_ready   = w_ready_s;
   assign strm.in_ready  = in_ready_s;
   assign strm.out_valid = out_valid_r;
   assign strm.out_data  = out_data_r;
   assign strm.out_last  = out_last_r;
   assign busy           = (state_r != IDLE);
   assign err            = err_r;
   assign done           = done_r;
endmodule

// File: tb/tb_conv1d_pe_row.sv
// Bench for conv1d_pe_row: three rows (ACC_W=32 SAT; ACC_W=16 SAT; ACC_W=16 wrap)
// share one stimulus stream; a reference model queues expected results and a
// negedge monitor pops and compares whenever a result handshakes.
module tb_conv1d_pe_row;
   localparam int NPE = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_start;
   logic [15:0] cfg_len;
   logic        w_valid;
   logic [7:0]  w_data;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        out_ready;

   always #5 clk = ~clk;

   conv1d_pe_row_if #(.DATA_W(8), .ACC_W(32)) if0 ();
   conv1d_pe_row_if #(.DATA_W(8), .ACC_W(16)) if1 ();
   conv1d_pe_row_if #(.DATA_W(8), .ACC_W(16)) if2 ();

   assign if0.w_valid = w_valid;   assign if1.w_valid = w_valid;   assign if2.w_valid = w_valid;
   assign if0.w_data = w_data;     assign if1.w_data = w_data;     assign if2.w_data = w_data;
   assign if0.in_valid = in_valid; assign if1.in_valid = in_valid; assign if2.in_valid = in_valid;
   assign if0.in_data = in_data;   assign if1.in_data = in_data;   assign if2.in_data = in_data;
   assign if0.out_ready = out_ready; assign if1.out_ready = out_ready; assign if2.out_ready = out_ready;

   logic [2:0]         busy_v, err_v, done_v, ov, ol;
   logic signed [31:0] od [3];

   assign ov = {if2.out_valid, if1.out_valid, if0.out_valid};
   assign ol = {if2.out_last, if1.out_last, if0.out_last};
   assign od[0] = $signed(if0.out_data);
   assign od[1] = {{16{if1.out_data[15]}}, if1.out_data};
   assign od[2] = {{16{if2.out_data[15]}}, if2.out_data};

   conv1d_pe_row #(.DATA_W(8), .NUM_PE(NPE), .ACC_W(32), .SAT(1)) dut0 (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_len(cfg_len), .strm(if0.slave),
      .busy(busy_v[0]), .err(err_v[0]), .done(done_v[0]));
   conv1d_pe_row #(.DATA_W(8), .NUM_PE(NPE), .ACC_W(16), .SAT(1)) dut1 (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_len(cfg_len), .strm(if1.slave),
      .busy(busy_v[1]), .err(err_v[1]), .done(done_v[1]));
   conv1d_pe_row #(.DATA_W(8), .NUM_PE(NPE), .ACC_W(16), .SAT(0)) dut2 (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_len(cfg_len), .strm(if2.slave),
      .busy(busy_v[2]), .err(err_v[2]), .done(done_v[2]));

   int checks = 0;
   int errors = 0;
   logic signed [7:0] wm [NPE];
   int     hist[$];
   int     acts_m[$];
   longint expq [3][$];
   bit     lastq [3][$];
   int     job_k;
   int     done_seen = 0;
   int     stall_cnt = 0;
   int     rdy_mode = 0;
   int     stall_left = 0;
   bit     err_exp = 1'b0;
   bit     held [3];
   bit     hl [3];
   longint hd [3];
   bit     pend_done [3];

   task automatic chk(input bit ok, input string nm, input longint act, input longint req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, req, $time);
      end
   endtask

   // Reference reduction: instance 0 is 32-bit saturating, 1 is 16-bit saturating, 2 is 16-bit wrapping.
   function automatic longint reduce(input longint s, input int j);
      int     aw;
      longint hi, lo, m;
      aw = (j == 0) ? 32 : 16;
      hi = (64'sd1 <<< (aw - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (j != 2) return (s > hi) ? hi : ((s < lo) ? lo : s);
      m = s & ((64'sd1 <<< aw) - 64'sd1);
      if (m > hi) m = m - (64'sd1 <<< aw);
      return m;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for the weight (is_w) or activation handshake currently offered.
   task automatic wait_hs(input bit is_w, output bit ok, output int iters);
      bit hs;
      hs = 1'b0;
      iters = 0;
      while (!hs && iters < 200) begin
         @(negedge clk);
         hs = is_w ? (w_valid && if0.w_ready) : (in_valid && if0.in_ready);
         @(posedge clk);
         #1;
         iters++;
      end
      ok = hs;
   endtask

   task automatic set_w(input int a, input int b, input int c);
      wm[0] = 8'(a);
      wm[1] = 8'(b);
      wm[2] = 8'(c);
   endtask

   task automatic start_job(input int k);
      hist.delete();
      job_k = k;
      cfg_start = 1'b1;
      cfg_len = 16'(k);
      tick();
      cfg_start = 1'b0;
      chk(busy_v == 3'b111, "busy_after_start", busy_v, 7);
   endtask

   task automatic load_weights();
      bit ok;
      int it;
      for (int i = 0; i < NPE; i++) begin
         w_valid = 1'b1;
         w_data = wm[i];
         wait_hs(1'b1, ok, it);
         if (!ok) chk(1'b0, "w_timeout", i, -1);
      end
      w_valid = 1'b0;
   endtask

   task automatic send_act(input int d, input int gap, input bit noise, input bit thru);
      bit     ok;
      int     it, n;
      longint s;
      if (gap > 0) begin
         in_valid = 1'b0;
         repeat (gap) tick();
      end
      in_valid = 1'b1;
      in_data = 8'(d);
      if (noise) begin
         cfg_start = 1'b1;
         cfg_len = 16'($urandom_range(0, 10));
      end
      wait_hs(1'b0, ok, it);
      cfg_start = 1'b0;
      if (!ok) begin
         chk(1'b0, "in_timeout", it, 1);
      end else begin
         if (thru) chk(it == 1, "no_bubble", it, 1);
         n = hist.size();
         hist.push_back(d);
         if (n >= NPE - 1) begin
            s = 0;
            for (int i = 0; i < NPE; i++) s += longint'(wm[i]) * longint'(hist[n-i]);
            for (int j = 0; j < 3; j++) begin
               expq[j].push_back(reduce(s, j));
               lastq[j].push_back(n == job_k - 1);
            end
         end
      end
   endtask

   task automatic run_job(input int k, input int gapmax, input bit noise, input bit thru);
      int prev, t;
      prev = done_seen;
      start_job(k);
      load_weights();
      for (int n = 0; n < k; n++) begin
         send_act(acts_m[n], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0, noise, thru);
      end
      in_valid = 1'b0;
      t = 0;
      while (done_seen == prev && t < 1000) begin
         tick();
         t++;
      end
      chk(done_seen == prev + 1, "job_done", done_seen - prev, 1);
      chk(busy_v == 3'b000, "busy_idle", busy_v, 0);
      chk(expq[0].size() + expq[1].size() + expq[2].size() == 0, "results_left",
          expq[0].size() + expq[1].size() + expq[2].size(), 0);
   endtask

   task automatic bad_len(input int k);
      err_exp = 1'b1;
      cfg_start = 1'b1;
      cfg_len = 16'(k);
      tick();
      cfg_start = 1'b0;
      chk(err_v == 3'b111, "err_pulse", err_v, 7);
      chk(busy_v == 3'b000, "err_busy", busy_v, 0);
      chk({if2.w_ready, if1.w_ready, if0.w_ready} == 3'b000, "err_w_ready",
          {if2.w_ready, if1.w_ready, if0.w_ready}, 0);
      tick();
      chk(err_v == 3'b000, "err_one_cycle", err_v, 0);
      chk(busy_v == 3'b000, "err_stays_idle", busy_v, 0);
      err_exp = 1'b0;
   endtask

   task automatic reset_checks(input string tag);
      chk(ov == 3'b000, {tag, "_out_valid"}, ov, 0);
      chk(ol == 3'b000, {tag, "_out_last"}, ol, 0);
      for (int j = 0; j < 3; j++) chk(od[j] == 0, {tag, "_out_data"}, od[j], 0);
      chk(busy_v == 3'b000, {tag, "_busy"}, busy_v, 0);
      chk(err_v == 3'b000, {tag, "_err"}, err_v, 0);
      chk(done_v == 3'b000, {tag, "_done"}, done_v, 0);
      chk({if0.w_ready, if0.in_ready, if1.w_ready, if1.in_ready, if2.w_ready, if2.in_ready} == 6'b0,
          {tag, "_ready"}, {if0.w_ready, if0.in_ready, if1.w_ready, if1.in_ready}, 0);
   endtask

   // out_ready driver: always ready, random, or one scripted 5-cycle stall
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            1: out_ready = ($urandom_range(0, 3) != 0);
            2: begin
               if (stall_left > 0 && if0.out_valid) begin
                  out_ready = 1'b0;
                  stall_left--;
               end else begin
                  out_ready = 1'b1;
               end
            end
            default: out_ready = 1'b1;
         endcase
      end
   end

   // Monitor: compares every result handshake against the scoreboard
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            for (int j = 0; j < 3; j++) begin
               held[j] = 1'b0;
               pend_done[j] = 1'b0;
            end
         end else begin
            if (err_v != 3'b000 && !err_exp) chk(1'b0, "spurious_err", err_v, 0);
            if (done_v[0]) done_seen++;
            for (int j = 0; j < 3; j++) begin
               if (pend_done[j]) begin
                  chk(done_v[j] && !busy_v[j], "done_pulse", {done_v[j], busy_v[j]}, 2);
                  pend_done[j] = 1'b0;
               end else if (done_v[j]) begin
                  chk(1'b0, "spurious_done", j, -1);
               end
               if (ov[j] && out_ready) begin
                  if (expq[j].size() == 0) begin
                     chk(1'b0, "unexpected_out", od[j], j);
                  end else begin
                     longint e;
                     bit     l;
                     e = expq[j].pop_front();
                     l = lastq[j].pop_front();
                     chk(od[j] == e, "out_data", od[j], e);
                     chk(ol[j] == l, "out_last", ol[j], l);
                     if (l) pend_done[j] = 1'b1;
                  end
                  held[j] = 1'b0;
               end else if (ov[j]) begin
                  if (held[j]) chk(od[j] == hd[j] && ol[j] == hl[j], "hold_stable", od[j], hd[j]);
                  if (j == 0) begin
                     chk(!if0.in_ready, "in_ready_stall", if0.in_ready, 0);
                     stall_cnt++;
                  end
                  held[j] = 1'b1;
                  hd[j] = od[j];
                  hl[j] = ol[j];
               end else begin
                  held[j] = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0; cfg_start = 1'b0; cfg_len = 16'd0; w_valid = 1'b0; w_data = 8'd0;
      in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b1;
      #12;
      reset_checks("por");
      #6 rst = 1'b1;
      tick();
      reset_checks("post_release");

      // basic job: 10 then 16 (last)
      set_w(1, 2, 3);
      acts_m = '{1, 2, 3, 4};
      run_job(4, 0, 1'b0, 1'b1);

      // same job with a 5-cycle stall on the first result
      stall_cnt = 0;
      stall_left = 5;
      rdy_mode = 2;
      run_job(4, 0, 1'b0, 1'b0);
      chk(stall_cnt >= 5, "stall_cycles", stall_cnt, 5);
      rdy_mode = 0;

      // rejected lengths
      bad_len(2);
      bad_len(0);

      // saturation / wrap: 48387 -> 48387, 32767, -17149
      set_w(127, 127, 127);
      acts_m = '{127, 127, 127};
      run_job(3, 0, 1'b0, 1'b1);

      // negative operands: 766
      set_w(-1, 2, -3);
      acts_m = '{-128, 127, -128};
      run_job(3, 0, 1'b0, 1'b1);

      // reset in the middle of COMPUTE
      set_w(1, 2, 3);
      start_job(6);
      load_weights();
      send_act(9, 0, 1'b0, 1'b0);
      send_act(-4, 0, 1'b0, 1'b0);
      in_valid = 1'b0;
      #2 rst = 1'b0;
      #1 reset_checks("async");
      for (int j = 0; j < 3; j++) begin
         expq[j].delete();
         lastq[j].delete();
      end
      @(negedge clk);
      #2 rst = 1'b1;
      tick();
      reset_checks("re_release");
      set_w(1, 1, 1);
      acts_m = '{5, 6, 7};
      run_job(3, 0, 1'b0, 1'b1);

      // randomized jobs; odd rounds add input gaps and random backpressure
      for (int r = 0; r < 8; r++) begin
         int k;
         k = int'($urandom_range(NPE, 16));
         for (int i = 0; i < NPE; i++) wm[i] = 8'($urandom_range(0, 255));
         acts_m.delete();
         for (int n = 0; n < k; n++) acts_m.push_back(int'($urandom_range(0, 255)) - 128);
         rdy_mode = r % 2;
         run_job(k, (r % 2 == 1) ? 2 : 0, 1'b1, (r % 2 == 0));
      end
      rdy_mode = 0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/conv1d_pe_row.md
CONV1D_PE_ROW -- requirements
Module: conv1d_pe_row

Interface
REQ-001 Parameter DATA_W, 8, signed width of weights and activations.
REQ-002 Parameter NUM_PE, 4, number of MAC processing elements (convolution taps), range 2..16.
REQ-003 Parameter ACC_W, 32, signed result width.
REQ-004 Parameter SAT, 1, 1 = saturate result to ACC_W signed range, 0 = two's-complement wrap.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 cfg_start  in  1  job start pulse, sampled only in IDLE.
REQ-008 cfg_len  in  16  number of activations in the job (K).
REQ-009 w_valid / w_ready / w_data  in / out / in  1 / 1 / DATA_W  weight stream, tap 0 first.
REQ-010 in_valid / in_ready / in_data  in / out / in  1 / 1 / DATA_W  activation stream.
REQ-011 out_valid / out_ready / out_data / out_last  out / in / out / out  1 / 1 / ACC_W / 1  result stream.
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 err  out  1  one-cycle pulse on rejected start.
REQ-014 done  out  1  one-cycle pulse when the job's final result handshakes.

Function
REQ-015 FSM states IDLE, LOAD_W, COMPUTE, DRAIN; transfer on any stream = valid && ready at a clock edge.
REQ-016 IDLE: cfg_start with cfg_len >= NUM_PE latches cfg_len, clears tap counter and window, -> LOAD_W; cfg_start with cfg_len < NUM_PE pulses err, stays IDLE.
REQ-017 cfg_start outside IDLE is ignored.
REQ-018 LOAD_W: w_ready = 1; transfer n stores w_data into weight register w[n]; after transfer NUM_PE-1 -> COMPUTE; w_ready = 0 in all other states.
REQ-019 COMPUTE: in_ready = !out_valid || out_ready (single output register, full throughput, no bubble under continuous out_ready).
REQ-020 Each activation transfer shifts the window: win[0] <= in_data, win[i] <= win[i-1]; accepted count increments.
REQ-021 On activation transfer number n (0-based) with n >= NUM_PE-1, next cycle out_valid = 1 and out_data = sum over i of w[i] * x[n-i], where x[n] = in_data and x[n-i] = win[i-1] pre-shift; latency exactly 1 cycle.
REQ-022 Transfers with n < NUM_PE-1 (warm-up) produce no output.
REQ-023 Products are full 2*DATA_W signed; sum kept at 2*DATA_W+clog2(NUM_PE) bits before reduction to ACC_W per SAT.
REQ-024 SAT=1: sums above 2^(ACC_W-1)-1 or below -2^(ACC_W-1) clamp to those limits; SAT=0: low ACC_W bits.
REQ-025 out_data, out_last held stable while out_valid && !out_ready.
REQ-026 out_last = 1 only on the result of activation n = K-1; total results per job = K-NUM_PE+1.
REQ-027 After activation K-1 transfers -> DRAIN; in_ready = 0 in DRAIN and IDLE.
REQ-028 DRAIN: on transfer of the out_last result, pulse done, -> IDLE.
REQ-029 Simultaneous output transfer and new activation transfer in one cycle: output register loads the new result, out_valid stays 1.

Reset
REQ-030 rst low asynchronously forces: state IDLE, weights, window, counters and out_data to 0, out_valid/out_last/busy/err/done/w_ready/in_ready 0.
REQ-031 Reset mid-job abandons the job; the next job requires a new cfg_start and full weight reload.
REQ-032 Outputs are valid from the first rising clk edge after rst returns high.

Verification (NUM_PE=3, DATA_W=8, ACC_W=32)
REQ-033 Basic: K=4, weights 1,2,3, inputs 1,2,3,4, out_ready=1 -> results 10 then 16, out_last on 16, done pulse, busy low after.
REQ-034 Backpressure: same job, out_ready low 5 cycles after first result -> 10 held stable, in_ready low, then 10 and 16 delivered in order, none lost or duplicated.
REQ-035 Bad length: cfg_start, K=2 -> err one cycle, busy stays 0, w_ready stays 0.
REQ-036 Saturation: ACC_W=16, SAT=1, weights 127,127,127, inputs 127 x3 -> 32767; SAT=0 -> low 16 bits of 48387 (-17149).
REQ-037 Negative values: weights -1,2,-3, inputs -128,127,-128 -> 128+254+384 = 766.
REQ-038 Reset mid-COMPUTE: rst low after 2 activations -> all outputs 0 asynchronously; new job K=3, weights 1,1,1, inputs 5,6,7 -> single result 18 with out_last.
